// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: computes a - b one 4-bit nibble per clock through a registered borrow chain
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a, b operand handshake;
//        out_valid/out_ready result handshake with diff, borrow, zero, ovf.
// Option: NIBBLE_SUB_SATURATE_EN floors diff to zero on borrow (zero flag still reports the raw result).
module nibble_serial_sub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             ovf
);
   localparam int N = WIDTH / 4;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0]       state;
   logic [WIDTH-1:0] a_r, b_r, diff_next;
   logic [IW-1:0]    idx;
   logic             carry, sa, sb;
   logic [4:0]       sum;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   // operands shift right each RUN cycle so the current nibble is always at [3:0];
   // result nibbles enter at the top and land in place after N shifts
   always_comb begin
      sum       = {1'b0, a_r[3:0]} + {1'b0, ~b_r[3:0]} + {4'd0, carry};
      diff_next = WIDTH'({sum[3:0], diff} >> 4);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         diff   <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
         idx    <= '0;
         carry  <= 1'b1;
      end else if (state == IDLE && in_valid) begin
         a_r   <= a;
         b_r   <= b;
         sa    <= a[WIDTH-1];
         sb    <= b[WIDTH-1];
         idx   <= '0;
         carry <= 1'b1;
         state <= RUN;
      end else if (state == RUN) begin
         a_r   <= a_r >> 4;
         b_r   <= b_r >> 4;
         carry <= sum[4];
         idx   <= idx + 1'b1;
         diff  <= diff_next;
         if (idx == LAST) begin
            state  <= DONE;
            borrow <= ~sum[4];
            zero   <= diff_next == '0;
            ovf    <= (sa != sb) & (diff_next[WIDTH-1] != sa);
`ifdef NIBBLE_SUB_SATURATE_EN
            diff   <= sum[4] ? diff_next : '0;
`else
            diff   <= diff_next;
`endif
         end
      end else if (state == DONE && out_ready) begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub: scoreboard bench for nibble_serial_sub against an arithmetic reference model
module tb_nibble_serial_sub;
   localparam int W = 16;
   localparam int N = W / 4;
   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         z;
      logic         ov;
      int           k;
   } exp_t;
   logic         clk, rst, in_valid, in_ready, out_valid, out_ready, borrow, zero, ovf;
   logic [W-1:0] a, b, diff;
   int           checks = 0, failures = 0, cyc = 0;
   logic         rdy_rand = 1'b0, rdy_fix = 1'b1;
   exp_t         exp_q[$];
   logic         prev_ov = 1'b0, prev_hs = 1'b0, prev_br, prev_z, prev_ovf;
   logic [W-1:0] prev_diff;

   nibble_serial_sub #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow),
      .zero(zero), .ovf(ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int k);
      exp_t e;
      int   r;
      r    = int'($signed(x)) - int'($signed(y));
      e.d  = x - y;
      e.br = x < y;
      e.z  = e.d == 0;
      e.ov = r > 32767 || r < -32768;
`ifdef NIBBLE_SUB_SATURATE_EN
      if (e.br) e.d = '0;
`endif
      e.k = k;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_ov = 1'b0;
         prev_hs = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
            else chk("latency", cyc - exp_q[0].k, N);
         end
         if (out_valid && prev_ov && !prev_hs) begin
            chk("hold_diff", diff, prev_diff);
            chk("hold_flags", {borrow, zero, ovf}, {prev_br, prev_z, prev_ovf});
         end
         if (out_valid) chk("in_ready_in_done", in_ready, 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("diff", diff, e.d);
               chk("borrow", borrow, e.br);
               chk("zero", zero, e.z);
               chk("ovf", ovf, e.ov);
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cyc + 1));
         prev_ov   = out_valid;
         prev_hs   = out_valid && out_ready;
         prev_diff = diff;
         prev_br   = borrow;
         prev_z    = zero;
         prev_ovf  = ovf;
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      int t;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = x;
      b = y;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 200);
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0 || out_valid) chk("drain_timeout", 0, 1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int           acc[3];
      int           t;
      logic [W-1:0] hd;
      logic [2:0]   hf;
      rst = 1'b1;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_flags", {borrow, zero, ovf}, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      send(16'h1234, 16'h0234);
      send(16'h0000, 16'h0001);
      send(16'h8000, 16'h0001);
      send(16'h7FFF, 16'hFFFF);
      drain();
      // backpressure: result held while out_ready is low, stray in_valid ignored
      @(negedge clk);
      rdy_fix = 1'b0;
      send(16'hABCD, 16'hABCD);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) chk("done_timeout", 0, 1);
      hd = diff;
      hf = {borrow, zero, ovf};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = i == 3;
         a = W'($urandom);
         b = W'($urandom);
         @(negedge clk);
         chk("bp_diff", diff, hd);
         chk("bp_flags", hf, {borrow, zero, ovf});
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      rdy_fix = 1'b1;
      drain();
      repeat (3) begin
         @(negedge clk);
         chk("ignored_pulse", out_valid, 0);
      end
      // reset in the middle of RUN
      send(16'h00FF, 16'h0001);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_diff", diff, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      send(16'h0005, 16'h0003);
      drain();
      // back-to-back with in_valid held high
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = pick();
      b = pick();
      for (int k = 0; k < 3; k++) begin
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!in_ready && t < 50);
         if (!in_ready) chk("b2b_timeout", 0, 1);
         acc[k] = cyc;
         @(posedge clk);
         #1;
         in_valid = k < 2;
         a = pick();
         b = pick();
      end
      chk("b2b_spacing0", acc[1] - acc[0], N + 2);
      chk("b2b_spacing1", acc[2] - acc[1], N + 2);
      drain();
      rdy_rand = 1'b1;
      repeat (40) send(pick(), pick());
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nibble_serial_sub.md
# nibble_serial_sub

Multi-cycle unsigned/two's-complement subtractor that computes `a - b` one 4-bit nibble per clock, carrying the borrow through a single registered bit between nibbles. It sits beside the combinational 4-bit lookahead adder slices in the datapath. It is used where a full-width parallel subtract is too large and a few cycles of latency are acceptable. It accepts operands on a valid/ready handshake and returns the difference plus borrow, zero and signed-overflow flags on a second valid/ready handshake.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4. Nibble count `N = WIDTH/4`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands `a`/`b` are valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: difference, `a - b` mod 2^WIDTH.
- `borrow` output 1: 1 when unsigned `a < b`.
- `zero` output 1: raw difference is all zeros.
- `ovf` output 1: signed two's-complement overflow.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - RUN: `in_ready=0`, `out_valid=0`.
  - DONE: `out_valid=1`, `in_ready=0`.
- IDLE -> RUN on `in_valid & in_ready`.
  - Capture `a` and `b` into registers.
  - Set nibble index to 0 and the carry register to 1, since subtraction is `a + ~b + 1`.
- Each RUN cycle, for nibble index i:
  - `sum = a[4i+3:4i] + ~b[4i+3:4i] + carry` (5-bit).
  - Write `sum[3:0]` into the `diff` register nibble i.
  - `carry <= sum[4]`.
  - Increment i.
- RUN -> DONE after nibble N-1 is processed. Flags are registered on the same edge:
  - `borrow = ~carry_final`.
  - `zero = (diff_raw == 0)`.
  - `ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff_raw[WIDTH-1] != a[WIDTH-1])`.
- DONE -> IDLE on `out_valid & out_ready`.
- In DONE, `diff`/`borrow`/`zero`/`ovf` hold stable until the result handshake completes.
- Captured operands are not affected by changes on `a`/`b` after acceptance.
- `in_valid` is ignored in RUN and DONE. There is no queuing.

## Timing
- Reset (`rst=1` at a rising edge):
  - State goes to IDLE.
  - `out_valid=0`, `diff=0`, `borrow=0`, `zero=0`, `ovf=0`.
  - Nibble index 0, carry 1.
- `in_ready` is decoded from state. It reads 1 during reset cycles, but handshakes sampled while `rst=1` are discarded.
- Latency:
  - Operands accepted at edge k.
  - `out_valid` is high after edge k+N (N RUN cycles).
- Throughput: one result per N+2 cycles at best.
  - The accept edge, N RUN edges, and the result handshake edge; IDLE is re-entered one cycle before the next accept.
  - The block does not accept new operands on the same edge as the result handshake.
- Backpressure: with `out_ready=0`, the block stays in DONE indefinitely with all outputs stable.
- Reset mid-RUN or mid-DONE:
  - Abandons the operation with no result produced.
  - Outputs return to their reset values on that edge.
- WIDTH=4: a single RUN cycle; behaves as a registered 4-bit subtract.

## Configuration
- `NIBBLE_SUB_SATURATE_EN`:
  - Defined: when `borrow=1`, the `diff` output is forced to all zeros (unsigned floor saturation). `zero` still reflects the raw difference, and `borrow`/`ovf` are unchanged.
  - Undefined: `diff` is always the modular difference.
  - Saturation is applied in the DONE-entry register update, not combinationally on the output.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234 -> after 4 RUN cycles `diff=0x1000`, `borrow=0`, `zero=0`, `ovf=0`. `out_valid` rises exactly 4 edges after accept.
- a=0x0000, b=0x0001 -> `diff=0xFFFF`, `borrow=1`, `ovf=0`. With `NIBBLE_SUB_SATURATE_EN` defined: `diff=0x0000`, `borrow=1`, `zero=0`.
- a=0x8000, b=0x0001 -> `diff=0x7FFF`, `borrow=0`, `ovf=1`. Also a=0x7FFF, b=0xFFFF -> `diff=0x8000`, `borrow=1`, `ovf=1`.
- a=b=0xABCD -> `diff=0x0000`, `zero=1`, `borrow=0`. Hold `out_ready=0` for 10 cycles: outputs stable, `in_ready=0`, and a new `in_valid` pulse is ignored.
- Accept a=0x00FF, b=0x0001, assert `rst` after 2 RUN cycles -> next cycle `out_valid=0`, `diff=0`, state IDLE. A following accept of a=0x0005, b=0x0003 yields `diff=0x0002`.
- Back-to-back: hold `in_valid=1` with `out_ready=1` for 3 transactions -> each result is correct and results are spaced N+2 cycles apart.
